// File: rtl/phys_free_list_pkg.sv
// rtl/phys_free_list_pkg.sv - sizing constants and pointer/register types for the physical free list
package phys_free_list_pkg;
    localparam int PHY_REGS  = 64;
    localparam int ARCH_REGS = 32;
    localparam int PHY_WIDTH = 6;
    localparam int FREE_REGS = PHY_REGS - ARCH_REGS;

    // One extra MSB on pointers tells a full ring from an empty one.
    typedef logic [PHY_WIDTH:0]   phy_ptr_t;
    typedef logic [PHY_WIDTH-1:0] phy_reg_t;
endpackage

// File: rtl/phys_free_list_if.sv
// rtl/phys_free_list_if.sv - rename/commit side bundle of the physical free list
interface phys_free_list_if;
    logic                                  flush;
    logic [1:0]                            free_list_valid;
    logic [phys_free_list_pkg::PHY_WIDTH-1:0] rd_phy_new_0;
    logic [phys_free_list_pkg::PHY_WIDTH-1:0] rd_phy_new_1;
    logic                                  free_list_stall;
    logic [phys_free_list_pkg::PHY_WIDTH:0]   free_count;
    logic [1:0]                            commit_alloc_valid;
    logic [1:0]                            commit_free_valid;
    logic [phys_free_list_pkg::PHY_WIDTH-1:0] commit_free_phy_0;
    logic [phys_free_list_pkg::PHY_WIDTH-1:0] commit_free_phy_1;

    modport master (
        output flush, free_list_valid, commit_alloc_valid, commit_free_valid,
               commit_free_phy_0, commit_free_phy_1,
        input  rd_phy_new_0, rd_phy_new_1, free_list_stall, free_count
    );

    modport slave (
        input  flush, free_list_valid, commit_alloc_valid, commit_free_valid,
               commit_free_phy_0, commit_free_phy_1,
        output rd_phy_new_0, rd_phy_new_1, free_list_stall, free_count
    );
endinterface

// File: rtl/fl_popcount2.sv
// rtl/fl_popcount2.sv - population count of a 2-bit valid vector
module fl_popcount2 (
    input  logic [1:0] bits,
    output logic [1:0] count
);
    assign count = {bits[1] & bits[0], bits[1] ^ bits[0]};
endmodule

// File: rtl/phys_free_list.sv
// rtl/phys_free_list.sv - rename-stage physical register free list, 2 grants and 2 reclaims per cycle
module phys_free_list
    import phys_free_list_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    phys_free_list_if.slave fl
);
    phy_reg_t   fifo [PHY_REGS];
    phy_ptr_t   head;
    phy_ptr_t   commit_head;
    phy_ptr_t   tail;
    phy_ptr_t   head_next;
    phy_ptr_t   commit_head_next;
    phy_ptr_t   count;
    phy_reg_t   rd_idx_0;
    phy_reg_t   rd_idx_1;
    phy_reg_t   wr_idx_0;
    phy_reg_t   wr_idx_1;
    logic [1:0] free_ok;
    logic [1:0] alloc_n;
    logic [1:0] free_n;
    logic [1:0] commit_n;
    logic       alloc_drop;

    // p0 is the hardwired zero register and never re-enters the pool.
    assign free_ok = {fl.commit_free_valid[1] && (fl.commit_free_phy_1 != '0),
                      fl.commit_free_valid[0] && (fl.commit_free_phy_0 != '0)};

    fl_popcount2 u_alloc_cnt  (.bits(fl.free_list_valid),    .count(alloc_n));
    fl_popcount2 u_free_cnt   (.bits(free_ok),               .count(free_n));
    fl_popcount2 u_commit_cnt (.bits(fl.commit_alloc_valid), .count(commit_n));

    assign count            = tail - head;
    assign alloc_drop       = !fl.flush && (count < phy_ptr_t'(alloc_n));
    assign commit_head_next = commit_head + phy_ptr_t'(commit_n);

    always_comb begin
        head_next = head;
        if (fl.flush)
            head_next = commit_head_next;
        else if (!alloc_drop)
            head_next = head + phy_ptr_t'(alloc_n);
    end

    // Slot 1 takes the head entry only when it is the sole requester.
    assign rd_idx_0 = head[PHY_WIDTH-1:0];
    assign rd_idx_1 = (fl.free_list_valid == 2'b10) ? rd_idx_0 : rd_idx_0 + phy_reg_t'(1);
    assign wr_idx_0 = tail[PHY_WIDTH-1:0];
    assign wr_idx_1 = free_ok[0] ? wr_idx_0 + phy_reg_t'(1) : wr_idx_0;

    assign fl.rd_phy_new_0    = fifo[rd_idx_0];
    assign fl.rd_phy_new_1    = fifo[rd_idx_1];
    assign fl.free_count      = count;
    assign fl.free_list_stall = count < phy_ptr_t'(2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head        <= '0;
            commit_head <= '0;
            tail        <= phy_ptr_t'(FREE_REGS);
            for (int i = 0; i < PHY_REGS; i++)
                fifo[i] <= (i < FREE_REGS) ? phy_reg_t'(ARCH_REGS + i) : '0;
        end else begin
            head        <= head_next;
            commit_head <= commit_head_next;
            tail        <= tail + phy_ptr_t'(free_n);
            if (free_ok[0])
                fifo[wr_idx_0] <= fl.commit_free_phy_0;
            if (free_ok[1])
                fifo[wr_idx_1] <= fl.commit_free_phy_1;
        end
    end

    sva_alloc_underflow: assert property (@(posedge clk) disable iff (!rst) !alloc_drop)
        else $warning("sva_alloc_underflow: request of %0d dropped with free_count %0d", alloc_n, count);

    sva_overflow: assert property (@(posedge clk) disable iff (!rst) count <= phy_ptr_t'(FREE_REGS))
        else $error("sva_overflow: free_count %0d above %0d", count, FREE_REGS);
endmodule

// File: tb/tb_phys_free_list.sv
// tb/tb_phys_free_list.sv - directed self-checking bench for phys_free_list
module tb_phys_free_list;
    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   total  = 0;

    phys_free_list_if fl_if ();

    phys_free_list dut (
        .clk (clk),
        .rst (rst),
        .fl  (fl_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fl_if.flush              = 1'b0;
        fl_if.free_list_valid    = 2'b00;
        fl_if.commit_alloc_valid = 2'b00;
        fl_if.commit_free_valid  = 2'b00;
        fl_if.commit_free_phy_0  = '0;
        fl_if.commit_free_phy_1  = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle();
        #2;
        do_reset();

        // reset image
        chk("reset_rd0", fl_if.rd_phy_new_0, 32);
        chk("reset_rd1", fl_if.rd_phy_new_1, 33);
        chk("reset_count", fl_if.free_count, 32);
        chk("reset_stall", fl_if.free_list_stall, 0);

        // three dual allocations
        fl_if.free_list_valid = 2'b11;
        #1;
        chk("dual0_rd0", fl_if.rd_phy_new_0, 32);
        chk("dual0_rd1", fl_if.rd_phy_new_1, 33);
        cyc();
        chk("dual1_rd0", fl_if.rd_phy_new_0, 34);
        chk("dual1_rd1", fl_if.rd_phy_new_1, 35);
        cyc();
        chk("dual2_rd0", fl_if.rd_phy_new_0, 36);
        chk("dual2_rd1", fl_if.rd_phy_new_1, 37);
        cyc();
        fl_if.free_list_valid = 2'b00;
        #1;
        chk("dual_count", fl_if.free_count, 26);
        chk("dual_stall", fl_if.free_list_stall, 0);

        // lone slot-1 request takes the head entry
        do_reset();
        fl_if.free_list_valid = 2'b10;
        #1;
        chk("lone1_rd1", fl_if.rd_phy_new_1, 32);
        cyc();
        fl_if.free_list_valid = 2'b00;
        #1;
        chk("lone1_next_rd0", fl_if.rd_phy_new_0, 33);
        chk("lone1_count", fl_if.free_count, 31);

        // drain the pool, then reclaim p5/p9 and a p0/p12 pair
        do_reset();
        repeat (16) begin
            fl_if.free_list_valid = 2'b11;
            cyc();
        end
        fl_if.free_list_valid = 2'b00;
        #1;
        chk("empty_count", fl_if.free_count, 0);
        chk("empty_stall", fl_if.free_list_stall, 1);
        fl_if.commit_free_valid = 2'b11;
        fl_if.commit_free_phy_0 = 6'd5;
        fl_if.commit_free_phy_1 = 6'd9;
        cyc();
        idle();
        #1;
        chk("reclaim_count", fl_if.free_count, 2);
        chk("reclaim_stall", fl_if.free_list_stall, 0);
        fl_if.free_list_valid = 2'b11;
        #1;
        chk("reclaim_rd0", fl_if.rd_phy_new_0, 5);
        chk("reclaim_rd1", fl_if.rd_phy_new_1, 9);
        cyc();
        fl_if.free_list_valid   = 2'b00;
        fl_if.commit_free_valid = 2'b11;
        fl_if.commit_free_phy_0 = 6'd0;
        fl_if.commit_free_phy_1 = 6'd12;
        cyc();
        idle();
        #1;
        chk("p0_free_count", fl_if.free_count, 1);
        chk("p0_free_rd0", fl_if.rd_phy_new_0, 12);

        // commit two, flush rewinds the speculative head
        do_reset();
        repeat (3) begin
            fl_if.free_list_valid = 2'b11;
            cyc();
        end
        fl_if.free_list_valid    = 2'b00;
        fl_if.commit_alloc_valid = 2'b11;
        cyc();
        fl_if.commit_alloc_valid = 2'b00;
        fl_if.flush              = 1'b1;
        fl_if.free_list_valid    = 2'b11;
        cyc();
        idle();
        #1;
        chk("flush_count", fl_if.free_count, 30);
        chk("flush_rd0", fl_if.rd_phy_new_0, 34);
        chk("flush_rd1", fl_if.rd_phy_new_1, 35);
        fl_if.free_list_valid = 2'b11;
        cyc();
        fl_if.free_list_valid = 2'b00;
        #1;
        chk("post_flush_count", fl_if.free_count, 28);
        fl_if.flush              = 1'b1;
        fl_if.commit_alloc_valid = 2'b01;
        fl_if.commit_free_valid  = 2'b01;
        fl_if.commit_free_phy_0  = 6'd7;
        cyc();
        idle();
        #1;
        chk("flush_commit_count", fl_if.free_count, 30);
        chk("flush_commit_rd0", fl_if.rd_phy_new_0, 35);

        // underflow: one entry free, dual request dropped
        do_reset();
        repeat (15) begin
            fl_if.free_list_valid = 2'b11;
            cyc();
        end
        fl_if.free_list_valid = 2'b01;
        cyc();
        fl_if.free_list_valid = 2'b00;
        #1;
        chk("one_left_count", fl_if.free_count, 1);
        chk("one_left_stall", fl_if.free_list_stall, 1);
        fl_if.free_list_valid = 2'b11;
        #1;
        chk("underflow_flag", dut.alloc_drop, 1);
        cyc();
        fl_if.free_list_valid = 2'b00;
        #1;
        chk("underflow_count", fl_if.free_count, 1);
        chk("underflow_rd0", fl_if.rd_phy_new_0, 63);
        fl_if.free_list_valid = 2'b01;
        cyc();
        fl_if.free_list_valid = 2'b00;
        #1;
        chk("last_alloc_count", fl_if.free_count, 0);

        // asynchronous reset mid-run
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_count", fl_if.free_count, 32);
        chk("async_rst_rd0", fl_if.rd_phy_new_0, 32);
        chk("async_rst_rd1", fl_if.rd_phy_new_1, 33);
        cyc();
        rst = 1'b1;
        cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
